id_decode_fsm: RTL and testbench

Parametrised instruction-decode stage between the fetch stage and the ALU/branch logic of the core. It consumes a word stream from fetch via valid/ready and decodes the opcode field. Two-word instructions (immediate/jump) take their operand from the following word. It issues one registered decode packet per instruction under a downstream valid/ready handshake, and back-pressures fetch through if_enable.

---
 rtl/id_decode_fsm.sv | 203 ++++++++++++++++++++
 tb/tb_id_decode_fsm.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_decode_fsm.sv
// Instruction-decode stage: turns a fetch word stream into registered decode packets.
// Optional illegal-opcode trap is enabled by defining ILLEGAL_TRAP_EN.
module id_decode_fsm #(
  parameter int WORD_W   = 8,
  parameter int OP_W     = 4,
  parameter int ALU_OP_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WORD_W-1:0]      in_word,
  output logic                   if_enable,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   alu_en,
  output logic [ALU_OP_W-1:0]    alu_op,
  output logic [WORD_W-OP_W-1:0] reg_sel,
  output logic [WORD_W-1:0]      imm,
  output logic                   imm_valid,
  output logic                   jmp_en,
  output logic                   halted,
  output logic                   trap
);

  localparam int RS_W = WORD_W - OP_W;

  localparam logic [1:0] FETCH_OP  = 2'd0;
  localparam logic [1:0] FETCH_IMM = 2'd1;
  localparam logic [1:0] HALTED    = 2'd2;

  logic [1:0]          state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic                alu_en_q, alu_en_d;
  logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
  logic [RS_W-1:0]     reg_sel_q, reg_sel_d;
  logic [WORD_W-1:0]   imm_q, imm_d;
  logic                imm_valid_q, imm_valid_d;
  logic                jmp_en_q, jmp_en_d;
  logic                halted_q, halted_d;
  logic                lat_jmp_q, lat_jmp_d;
  logic [RS_W-1:0]     lat_reg_q, lat_reg_d;
`ifdef ILLEGAL_TRAP_EN
  logic                trap_q, trap_d;
`endif

  logic [OP_W-1:0] op_s;
  logic [RS_W-1:0] word_reg_s;
  logic            slot_free_s;
  logic            accept_s;

  assign op_s        = in_word[WORD_W-1 -: OP_W];
  assign word_reg_s  = in_word[RS_W-1:0];
  assign slot_free_s = !out_valid_q || out_ready;
  assign accept_s    = in_valid && if_enable;
  assign if_enable   = slot_free_s && (state_q != HALTED);

  // Next-state and packet-load logic; packet fields hold unless a new packet loads.
  always_comb begin
    state_d     = state_q;
    alu_en_d    = alu_en_q;
    alu_op_d    = alu_op_q;
    reg_sel_d   = reg_sel_q;
    imm_d       = imm_q;
    imm_valid_d = imm_valid_q;
    jmp_en_d    = jmp_en_q;
    halted_d    = halted_q;
    lat_jmp_d   = lat_jmp_q;
    lat_reg_d   = lat_reg_q;
`ifdef ILLEGAL_TRAP_EN
    trap_d      = trap_q;
`endif
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      FETCH_OP: begin
        if (accept_s) begin
          case (op_s)
            OP_W'(1), OP_W'(2), OP_W'(3), OP_W'(4), OP_W'(5): begin
              out_valid_d = 1'b1;
              alu_en_d    = 1'b1;
              alu_op_d    = ALU_OP_W'(op_s - OP_W'(1));
              reg_sel_d   = word_reg_s;
              imm_d       = '0;
              imm_valid_d = 1'b0;
              jmp_en_d    = 1'b0;
`ifdef ILLEGAL_TRAP_EN
              trap_d      = 1'b0;
`endif
            end
            OP_W'(6), OP_W'(7): begin
              // opcode bit 0 separates JMP (7) from LDI (6)
              lat_jmp_d = op_s[0];
              lat_reg_d = word_reg_s;
              state_d   = FETCH_IMM;
            end
            OP_W'(0): begin
              state_d = FETCH_OP;
            end
            OP_W'(15): begin
              state_d  = HALTED;
              halted_d = 1'b1;
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
              out_valid_d = 1'b1;
              alu_en_d    = 1'b0;
              alu_op_d    = '0;
              reg_sel_d   = '0;
              imm_d       = '0;
              imm_valid_d = 1'b0;
              jmp_en_d    = 1'b0;
              trap_d      = 1'b1;
              state_d     = HALTED;
              halted_d    = 1'b1;
`else
              state_d = FETCH_OP;
`endif
            end
          endcase
        end else begin
          state_d = FETCH_OP;
        end
      end
      FETCH_IMM: begin
        if (accept_s) begin
          out_valid_d = 1'b1;
          alu_en_d    = 1'b0;
          alu_op_d    = '0;
          reg_sel_d   = lat_reg_q;
          imm_d       = in_word;
          imm_valid_d = 1'b1;
          jmp_en_d    = lat_jmp_q;
`ifdef ILLEGAL_TRAP_EN
          trap_d      = 1'b0;
`endif
          state_d     = FETCH_OP;
        end else begin
          state_d = FETCH_IMM;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH_OP;
      end
    endcase
  end

  // State and packet registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH_OP;
      out_valid_q <= 1'b0;
      alu_en_q    <= 1'b0;
      alu_op_q    <= '0;
      reg_sel_q   <= '0;
      imm_q       <= '0;
      imm_valid_q <= 1'b0;
      jmp_en_q    <= 1'b0;
      halted_q    <= 1'b0;
      lat_jmp_q   <= 1'b0;
      lat_reg_q   <= '0;
`ifdef ILLEGAL_TRAP_EN
      trap_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      alu_en_q    <= alu_en_d;
      alu_op_q    <= alu_op_d;
      reg_sel_q   <= reg_sel_d;
      imm_q       <= imm_d;
      imm_valid_q <= imm_valid_d;
      jmp_en_q    <= jmp_en_d;
      halted_q    <= halted_d;
      lat_jmp_q   <= lat_jmp_d;
      lat_reg_q   <= lat_reg_d;
`ifdef ILLEGAL_TRAP_EN
      trap_q      <= trap_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign alu_en    = alu_en_q;
  assign alu_op    = alu_op_q;
  assign reg_sel   = reg_sel_q;
  assign imm       = imm_q;
  assign imm_valid = imm_valid_q;
  assign jmp_en    = jmp_en_q;
  assign halted    = halted_q;
`ifdef ILLEGAL_TRAP_EN
  assign trap      = trap_q;
`else
  assign trap      = 1'b0;
`endif

endmodule

// File: tb/tb_id_decode_fsm.sv
// Directed plus randomized bench for id_decode_fsm; expected packets come from an
// instruction-level model built from the generated program.
module tb_id_decode_fsm;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_word;
  logic       if_enable;
  logic       out_valid;
  logic       out_ready;
  logic       alu_en;
  logic [2:0] alu_op;
  logic [3:0] reg_sel;
  logic [7:0] imm;
  logic       imm_valid;
  logic       jmp_en;
  logic       halted;
  logic       trap;

  int checks = 0;
  int errors = 0;

  logic [7:0]  words[$];
  logic [31:0] expq[$];
  int op, r, o, idx, guard;
  logic acc, take;

  id_decode_fsm dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word),
    .if_enable(if_enable), .out_valid(out_valid), .out_ready(out_ready),
    .alu_en(alu_en), .alu_op(alu_op), .reg_sel(reg_sel), .imm(imm),
    .imm_valid(imm_valid), .jmp_en(jmp_en), .halted(halted), .trap(trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic ae, input logic [2:0] aop, input logic [3:0] rs,
                                     input logic [7:0] im, input logic iv, input logic je,
                                     input logic tr);
    return {13'd0, ae, aop, rs, im, iv, je, tr};
  endfunction

  function automatic logic [31:0] obs_pkt();
    return pk(alu_en, alu_op, reg_sel, imm, imm_valid, jmp_en, trap);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one word and wait (bounded) until it is accepted.
  task automatic send(input logic [7:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_word  = w;
    #1;
    while (!if_enable && n < 50) begin
      cyc();
      n++;
    end
    if (!if_enable) begin
      chk("send_timeout", {31'd0, if_enable}, 32'd1);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pkt"}, obs_pkt(), 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
    chk({tag, "_if_enable"}, {31'd0, if_enable}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_word = 8'h00; out_ready = 1'b0;
    #2;
    check_zero("reset_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // back-to-back ALU ops
    send(8'h15);
    chk("add_pkt", obs_pkt(), pk(1'b1, 3'd0, 4'd5, 8'h00, 1'b0, 1'b0, 1'b0));
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    send(8'h23);
    chk("sub_pkt", obs_pkt(), pk(1'b1, 3'd1, 4'd3, 8'h00, 1'b0, 1'b0, 1'b0));
    chk("sub_valid", {31'd0, out_valid}, 32'd1);
    cyc();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_hold", obs_pkt(), pk(1'b1, 3'd1, 4'd3, 8'h00, 1'b0, 1'b0, 1'b0));

    // two-word instructions
    send(8'h62);
    chk("ldi_no_pkt_yet", {31'd0, out_valid}, 32'd0);
    send(8'hA5);
    chk("ldi_valid", {31'd0, out_valid}, 32'd1);
    chk("ldi_pkt", obs_pkt(), pk(1'b0, 3'd0, 4'd2, 8'hA5, 1'b1, 1'b0, 1'b0));
    send(8'h70);
    send(8'h40);
    chk("jmp_valid", {31'd0, out_valid}, 32'd1);
    chk("jmp_pkt", obs_pkt(), pk(1'b0, 3'd0, 4'd0, 8'h40, 1'b1, 1'b1, 1'b0));

    // back-pressure
    send(8'h13);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_word = 8'h24;
    #1;
    chk("bp_if_enable0", {31'd0, if_enable}, 32'd0);
    repeat (5) begin
      cyc();
      chk("bp_if_enable", {31'd0, if_enable}, 32'd0);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold", obs_pkt(), pk(1'b1, 3'd0, 4'd3, 8'h00, 1'b0, 1'b0, 1'b0));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release", {31'd0, if_enable}, 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_next_pkt", obs_pkt(), pk(1'b1, 3'd1, 4'd4, 8'h00, 1'b0, 1'b0, 1'b0));

    // reset between LDI opcode and operand
    send(8'h61);
    #2;
    rst = 1'b1;
    #1;
    check_zero("reset_mid");
    rst = 1'b0;
    send(8'h30);
    chk("mid_and_valid", {31'd0, out_valid}, 32'd1);
    chk("mid_and_pkt", obs_pkt(), pk(1'b1, 3'd2, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0));
    cyc();

    // randomized program against instruction-level model
    for (int i = 0; i < 200; i++) begin
      op = int'($urandom_range(0, 7));
      r  = int'($urandom_range(0, 15));
      o  = int'($urandom_range(0, 255));
      words.push_back(8'(op * 16 + r));
      if (op >= 1 && op <= 5) begin
        expq.push_back(pk(1'b1, 3'(op - 1), 4'(r), 8'h00, 1'b0, 1'b0, 1'b0));
      end else if (op == 6 || op == 7) begin
        words.push_back(8'(o));
        expq.push_back(pk(1'b0, 3'd0, 4'(r), 8'(o), 1'b1, op == 7, 1'b0));
      end
    end
    idx = 0;
    guard = 0;
    while ((idx < words.size() || expq.size() != 0) && guard < 20000) begin
      in_valid  = (idx < words.size()) && ($urandom_range(0, 3) != 0);
      in_word   = (idx < words.size()) ? words[idx] : 8'h00;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_if_enable", {31'd0, if_enable}, {31'd0, (!out_valid || out_ready)});
      acc  = in_valid && if_enable;
      take = out_valid && out_ready;
      if (take) begin
        if (expq.size() == 0) begin
          chk("rnd_extra_pkt", {31'd0, out_valid}, 32'd0);
        end else begin
          chk("rnd_pkt", obs_pkt(), expq.pop_front());
        end
      end
      @(posedge clk);
      #1;
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    chk("rnd_drained", 32'(expq.size()), 32'd0);
    chk("rnd_consumed", 32'(idx), 32'(words.size()));

    // HALT: prior OR drains, later ADD never issues
    out_ready = 1'b1;
    cyc();
    send(8'h41);
    chk("or_pkt", obs_pkt(), pk(1'b1, 3'd3, 4'd1, 8'h00, 1'b0, 1'b0, 1'b0));
    send(8'hF0);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1;
    in_word = 8'h10;
    repeat (5) begin
      cyc();
      chk("halt_if_enable", {31'd0, if_enable}, 32'd0);
      chk("halt_no_pkt", {31'd0, out_valid}, 32'd0);
      chk("halt_stays", {31'd0, halted}, 32'd1);
    end
    in_valid = 1'b0;

    // illegal opcode
    rst = 1'b1;
    #1;
    check_zero("reset_halt");
    rst = 1'b0;
    send(8'h90);
`ifdef ILLEGAL_TRAP_EN
    chk("ill_valid", {31'd0, out_valid}, 32'd1);
    chk("ill_pkt", obs_pkt(), pk(1'b0, 3'd0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1));
    chk("ill_halted", {31'd0, halted}, 32'd1);
    chk("ill_if_enable", {31'd0, if_enable}, 32'd0);
`else
    chk("ill_no_pkt", {31'd0, out_valid}, 32'd0);
    chk("ill_trap", {31'd0, trap}, 32'd0);
    chk("ill_not_halted", {31'd0, halted}, 32'd0);
    send(8'h50);
    chk("ill_xor_valid", {31'd0, out_valid}, 32'd1);
    chk("ill_xor_pkt", obs_pkt(), pk(1'b1, 3'd4, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
